// File: rtl/imem_loadable.sv
// Loadable instruction memory: post-reset clear sequencer, program-load port,
// registered fetch with valid/ready. Define IMEM_PARITY_EN for per-word even parity.
module imem_loadable #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 64,
  parameter int                ADDR_W      = 32,
  parameter logic [DATA_W-1:0] RESET_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] instr,
  output logic              fetch_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`ifdef IMEM_PARITY_EN
  input  logic              par_flip,
`endif
  output logic              prog_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  state_t            r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_instr;
  logic              r_fetch_fault;
  logic              r_prog_err;
  logic              r_init_done;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_fetch_ready;
  logic              w_accept;
  logic              w_clearing;
  logic              w_prog_ok;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_addr_flt;
  logic              w_rsp_fault;

  assign w_clearing    = (r_state == S_CLEAR);
  assign w_fetch_ready = (r_state == S_RUN) && !prog_we && (!r_rsp_valid || rsp_ready);
  assign w_accept      = fetch_req && w_fetch_ready;
  assign w_prog_ok     = prog_we && (r_state == S_RUN) && !addr_fault(prog_addr);
  assign w_mem_we      = w_clearing || w_prog_ok;
  assign w_wr_idx      = w_clearing ? r_cnt : word_idx(prog_addr);
  assign w_wr_data     = w_clearing ? RESET_INSTR : prog_data;
  assign w_rd_word     = r_mem[word_idx(fetch_addr)];
  assign w_addr_flt    = addr_fault(fetch_addr);

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];
  logic w_wr_par;
  logic w_par_bad;

  // Flip only applies to program writes so the clear pattern is always clean.
  assign w_wr_par    = (^w_wr_data) ^ (!w_clearing && par_flip);
  assign w_par_bad   = (^w_rd_word) != r_par[word_idx(fetch_addr)];
  assign w_rsp_fault = w_addr_flt || w_par_bad;
`else
  assign w_rsp_fault = w_addr_flt;
`endif

  // Storage has no reset; the clear sequencer initialises it after every reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wr_idx] <= w_wr_data;
`ifdef IMEM_PARITY_EN
      r_par[w_wr_idx] <= w_wr_par;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_CLEAR;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_instr       <= '0;
      r_fetch_fault <= 1'b0;
      r_prog_err    <= 1'b0;
      r_init_done   <= 1'b0;
    end else begin
      r_prog_err <= prog_we && (w_clearing || addr_fault(prog_addr));
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(DEPTH - 1)) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
      r_rsp_valid <= w_accept || (r_rsp_valid && !rsp_ready);
      if (w_accept) begin
        r_instr       <= w_addr_flt ? RESET_INSTR : w_rd_word;
        r_fetch_fault <= w_rsp_fault;
      end
    end
  end

  assign fetch_ready = w_fetch_ready;
  assign rsp_valid   = r_rsp_valid;
  assign instr       = r_instr;
  assign fetch_fault = r_fetch_fault;
  assign prog_err    = r_prog_err;
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: clear sequence, table-driven fetch/program
// vectors, backpressure, async reset mid-stream and (if IMEM_PARITY_EN) parity faults.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_err;
  logic        init_done;
`ifdef IMEM_PARITY_EN
  logic        par_flip;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loadable dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .instr      (instr),
    .fetch_fault(fetch_fault),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
`ifdef IMEM_PARITY_EN
    .par_flip   (par_flip),
`endif
    .prog_err   (prog_err),
    .init_done  (init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [31:0] faddr;
    logic        rdy;
    logic        we;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        e_fr;
    logic        e_rv;
    logic [31:0] e_instr;
    logic        e_ff;
    logic        e_pe;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy;
    int n;
    //           req  faddr         rdy  we   paddr         pdata         fr   rv   instr         ff   pe
    vt[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h00000013, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'h8,        1'b1, 1'b1, 32'h8,        32'h00508113, 1'b0, 1'b0, 32'h00000013, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h00100093, 1'b0, 1'b0, 32'h00000013, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFC,       32'h7FF00113, 1'b0, 1'b0, 32'h00000013, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 32'h8,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00508113, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 32'h6,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00000013, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 32'h100,      1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00000013, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 32'hFC,       1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h7FF00113, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h102,      32'hDEADBEEF, 1'b0, 1'b0, 32'h7FF00113, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0};
    vt[10] = '{1'b1, 32'h4,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00100093, 1'b0, 1'b0};
    vt[11] = '{1'b1, 32'h8,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00508113, 1'b0, 1'b0};
    vt[12] = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00508113, 1'b0, 1'b0};
    vt[13] = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00508113, 1'b0, 1'b0};
    vt[14] = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00508113, 1'b0, 1'b0};
    vt[15] = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0};
    vt[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h00000013, 1'b0, 1'b0};
    vt[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h12345678, 1'b0, 1'b0, 32'h00000013, 1'b0, 1'b1};

    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0; rsp_ready = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
`ifdef IMEM_PARITY_EN
    par_flip = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_prog_err", prog_err, 0);
    chk("rst_fetch_fault", fetch_fault, 0);

    // Clear phase: fetch held pending, must stall for exactly DEPTH cycles.
    @(negedge clk);
    reset = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
    busy = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!fetch_ready && !init_done) busy++;
      @(negedge clk);
    end
    chk("clear_busy_cycles", busy, 64);
    #1;
    chk("init_done_c65", init_done, 1);
    chk("fetch_ready_c65", fetch_ready, 1);
    @(posedge clk); #1;
    chk("first_rsp_valid", rsp_valid, 1);
    chk("first_instr", instr, 32'h00000013);
    chk("first_fault", fetch_fault, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      fetch_req = vt[i].req; fetch_addr = vt[i].faddr; rsp_ready = vt[i].rdy;
      prog_we = vt[i].we; prog_addr = vt[i].paddr; prog_data = vt[i].pdata;
      #1;
      chk($sformatf("v%0d_fetch_ready", i), fetch_ready, vt[i].e_fr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vt[i].e_rv);
      chk($sformatf("v%0d_instr", i), instr, vt[i].e_instr);
      chk($sformatf("v%0d_fetch_fault", i), fetch_fault, vt[i].e_ff);
      chk($sformatf("v%0d_prog_err", i), prog_err, vt[i].e_pe);
    end

    // Async reset while a response is outstanding.
    @(negedge clk);
    prog_we = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h8; rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    chk("pre_rst_instr", instr, 32'h00508113);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_instr", instr, 0);
    chk("async_rst_init_done", init_done, 0);
    chk("async_rst_fetch_ready", fetch_ready, 0);

    @(negedge clk);
    reset = 1'b1; fetch_req = 1'b0; rsp_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 32'h4; prog_data = 32'h11111113;
    @(posedge clk); #1;
    chk("clear_prog_err", prog_err, 1);
    @(negedge clk);
    prog_we = 1'b0;
    n = 0;
    while (!init_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reclear_init_done", init_done, 1);
    chk("reclear_cycles", n, 63);

    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h8;
    @(posedge clk); #1;
    chk("reclear_w8_valid", rsp_valid, 1);
    chk("reclear_w8_instr", instr, 32'h00000013);
    @(negedge clk); fetch_addr = 32'h4;
    @(posedge clk); #1;
    chk("reclear_w4_instr", instr, 32'h00000013);
    @(negedge clk); fetch_addr = 32'hFC;
    @(posedge clk); #1;
    chk("reclear_w63_instr", instr, 32'h00000013);
    chk("reclear_w63_fault", fetch_fault, 0);

`ifdef IMEM_PARITY_EN
    @(negedge clk);
    fetch_req = 1'b0; prog_we = 1'b1; prog_addr = 32'h4; prog_data = 32'h00A00093; par_flip = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; par_flip = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h4;
    @(posedge clk); #1;
    chk("par_bad_fault", fetch_fault, 1);
    chk("par_bad_instr", instr, 32'h00A00093);
    @(negedge clk);
    fetch_req = 1'b0; prog_we = 1'b1; prog_addr = 32'h4; prog_data = 32'h00A00093; par_flip = 1'b0;
    @(negedge clk);
    prog_we = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h4;
    @(posedge clk); #1;
    chk("par_ok_fault", fetch_fault, 0);
    chk("par_ok_instr", instr, 32'h00A00093);
`endif

    @(negedge clk);
    fetch_req = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory that supersedes the fixed 64-word ROM-style array.
- Adds a program-load write port, a post-reset clear sequencer, and a registered fetch path with valid/ready handshake.
- Adds alignment and range fault reporting.
- Sits between the fetch stage (PC byte address in, instruction out) and the test/boot loader.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of words; must be a power of 2, ≥ 2.
- ADDR_W, 32, byte-address width of the fetch and program ports.
- RESET_INSTR, 32'h00000013, word written by the clear sequencer and returned on a fault (RISC-V NOP, addi x0,x0,0).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- fetch_req, input, 1, fetch request; qualified by fetch_ready.
- fetch_addr, input, ADDR_W, fetch byte address (PC).
- fetch_ready, output, 1, block can accept a fetch this cycle.
- rsp_valid, output, 1, instr/fault are valid.
- rsp_ready, input, 1, consumer accepts the response.
- instr, output, DATA_W, fetched instruction.
- fetch_fault, output, 1, response came from a misaligned or out-of-range address.
- prog_we, input, 1, program-load write strobe.
- prog_addr, input, ADDR_W, byte address for the load write.
- prog_data, input, DATA_W, word to write.
- prog_err, output, 1, one-cycle pulse: rejected load write.
- init_done, output, 1, clear sequencer has finished.

Behaviour:
- Word index = addr[log2(DEPTH)+1:2].
- Misaligned: addr[1:0] != 0.
- Out of range: any of addr[ADDR_W-1:log2(DEPTH)+2] nonzero.
- Reset asserted (async):
  - FSM goes to CLEAR; clear counter = 0.
  - rsp_valid=0, instr=0, fetch_fault=0, prog_err=0, init_done=0.
  - Array contents are not reset asynchronously.
- FSM states:
  - CLEAR: writes RESET_INSTR to word[cnt] each cycle, cnt++. After word DEPTH-1 is written, goes to RUN next edge, so CLEAR lasts exactly DEPTH cycles. init_done=1 from the first RUN cycle.
  - RUN: normal operation.
  - Reset asserted during CLEAR or RUN restarts CLEAR from word 0.
- fetch_ready = (state==RUN) && !prog_we && (!rsp_valid || rsp_ready).
- Fetch accept (fetch_req && fetch_ready):
  - Response is registered; rsp_valid=1 on the next edge (1-cycle latency).
  - Valid address: instr = word[index], fetch_fault=0.
  - Faulted address: instr = RESET_INSTR, fetch_fault=1.
- Backpressure: while rsp_valid && !rsp_ready, instr and fetch_fault hold stable and fetch_ready=0.
- Response consumed with no new accept: rsp_valid drops next edge; instr holds its last value.
- Same-cycle consume and accept: rsp_valid stays 1 and the response updates; back-to-back throughput is 1 per cycle.
- Program writes:
  - In RUN, prog_we with a valid address writes word[index] at the edge.
  - A fetch of that word accepted in a later cycle returns the new data.
  - prog_we has priority: it forces fetch_ready=0, so a read and a write never happen in the same cycle.
- prog_err pulses for one cycle, with no write performed, when:
  - prog_we is asserted in CLEAR, or
  - prog_we is asserted with a misaligned or out-of-range address.
- Word index wraps nowhere; out-of-range addresses never alias.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write (clear and program writes).
  - Fetch recomputes parity; on mismatch the response carries fetch_fault=1 and the stored (corrupt) data.
  - Adds a debug input par_flip (1 bit) that inverts the stored parity bit on a program write, for test.
- Undefined: no parity storage, no par_flip port; fetch_fault reflects address faults only.

Test Plan:
- Release reset, hold fetch_req=1, fetch_addr=0 -> fetch_ready=0 for 64 cycles, init_done=1 in cycle 65; first response instr=32'h00000013, fetch_fault=0.
- After init, prog_we at addr 0x8 with 32'h00508113; next cycle fetch 0x8 -> rsp_valid one cycle later, instr=32'h00508113, fetch_fault=0.
- Fetch 0x6 -> fault, instr=32'h00000013. Fetch 0x100 (DEPTH=64) -> fault. prog_we to 0x102 -> prog_err pulse, and a later fetch of 0x0 is unchanged.
- Back-to-back fetches 0x0,0x4,0x8 with rsp_ready=1 -> three consecutive rsp_valid cycles. Then rsp_ready=0 for 3 cycles -> instr stable, fetch_ready=0; on release, the pending response is consumed and the next fetch is accepted in the same cycle.
- Assert reset mid-stream with rsp_valid=1 -> rsp_valid=0 and instr=0 immediately (async); CLEAR restarts and previously programmed words read back 32'h00000013.
- IMEM_PARITY_EN: program 0x4 with par_flip=1, fetch 0x4 -> fetch_fault=1 with stored data returned; reprogram with par_flip=0 -> fetch_fault=0.
